// File: rtl/con_pkg.sv
// con_pkg: shared diagnostic function codes, NICOND dispatch codes and diag_data field offsets.
// Ports: none (package).
package con_pkg;

   typedef enum logic [2:0] {
      DF_CLR_RUN     = 3'b000,
      DF_SET_RUN     = 3'b001,
      DF_CONTINUE    = 3'b010,
      DF_IR_STROBE   = 3'b100,
      DF_DRAM_STROBE = 3'b101,
      DF_HALTCNT     = 3'b111
   } diag_func_e;

   localparam logic [2:0] NC_PI     = 3'b000;
   localparam logic [2:0] NC_HALT   = 3'b001;
   localparam logic [2:0] NC_METER  = 3'b010;
   localparam logic [2:0] NC_INT    = 3'b011;
   localparam logic [2:0] NC_USTATE = 3'b100;
   localparam logic [2:0] NC_NOAC   = 3'b101;
   localparam logic [2:0] NC_NONE   = 3'b111;

   localparam int DD_RUN    = 15;
   localparam int DD_START  = 14;
   localparam int DD_GO     = 13;
   localparam int DD_INT    = 12;
   localparam int DD_TRAP   = 11;
   localparam int DD_NICOND = 8;
   localparam int DD_USTATE = 0;

endpackage

// File: rtl/con_runctl_if.sv
// con_runctl_if: control/status bundle of the run controller.
// master: drives diag_ctl, diag_func, int_src, int_disable, go_hold, pi_cycle, ac_ref,
//         ustate_en, ustate_mag, diag_rd; observes all status outputs.
// slave:  the reverse (used by con_runctl).
interface con_runctl_if #(
   parameter int NSRC   = 4,
   parameter int NSTATE = 4
);
   logic                  diag_ctl;
   logic [2:0]            diag_func;
   logic [NSRC-1:0]       int_src;
   logic                  int_disable;
   logic                  go_hold;
   logic                  pi_cycle;
   logic                  ac_ref;
   logic                  ustate_en;
   logic [2*NSTATE-1:0]   ustate_mag;
   logic                  diag_rd;
   logic                  RUN;
   logic                  START;
   logic                  INSTR_GO;
   logic                  DIAG_IR_STROBE;
   logic                  DIAG_DRAM_STROBE;
   logic                  INT_REQ;
   logic [2:0]            NICOND;
   logic                  NICOND_TRAP_EN;
   logic [NSTATE-1:0]     UCODE_STATE;
   logic [15:0]           diag_data;

   modport master (
      output diag_ctl, diag_func, int_src, int_disable, go_hold, pi_cycle, ac_ref,
             ustate_en, ustate_mag, diag_rd,
      input  RUN, START, INSTR_GO, DIAG_IR_STROBE, DIAG_DRAM_STROBE, INT_REQ, NICOND,
             NICOND_TRAP_EN, UCODE_STATE, diag_data
   );

   modport slave (
      input  diag_ctl, diag_func, int_src, int_disable, go_hold, pi_cycle, ac_ref,
             ustate_en, ustate_mag, diag_rd,
      output RUN, START, INSTR_GO, DIAG_IR_STROBE, DIAG_DRAM_STROBE, INT_REQ, NICOND,
             NICOND_TRAP_EN, UCODE_STATE, diag_data
   );

endinterface

// File: rtl/con_runctl_sync_chain.sv
// sync_chain: W parallel delay lines of STAGES registers each, with per-line flush.
// Ports: clk, RESET (async, active high), d_i (line inputs), clr_i (flush whole line,
//        input stage included), q_o (line outputs, STAGES cycles after d_i).
module sync_chain #(
   parameter int STAGES = 3,
   parameter int W      = 2
) (
   input  logic         clk,
   input  logic         RESET,
   input  logic [W-1:0] d_i,
   input  logic [W-1:0] clr_i,
   output logic [W-1:0] q_o
);
   logic [STAGES-1:0][W-1:0] s_q;

   always_ff @(posedge clk or posedge RESET)
      if (RESET) s_q <= '0;
      else begin
         s_q[0] <= d_i & ~clr_i;
         for (int i = 1; i < STAGES; i++) s_q[i] <= s_q[i-1] & ~clr_i;
      end

   assign q_o = s_q[STAGES-1];

endmodule

// File: rtl/con_runctl.sv
// con_runctl: EBOX run/start/instruction-go control, interrupt summary and NICOND dispatch.
// Ports: clk, RESET (async, active high), bus (con_runctl_if.slave: diagnostic strobes,
//        interrupt sources, microcode state loads in; RUN/START/INSTR_GO, NICOND, status out).
// Option: CON_RUNCTL_HALTCNT_EN adds a saturating halted-cycle counter read via diag_func=111.
module con_runctl
   import con_pkg::*;
#(
   parameter int SYNC_STAGES = 3,
   parameter int NSRC        = 4,
   parameter int NSTATE      = 4
) (
   input  logic         clk,
   input  logic         RESET,
   con_runctl_if.slave  bus
);
   logic              clr_run, set_run, cont;
   logic              run_q, run_d, start_q, start_d, go_q, go_d, trap_q;
   logic              run_o, start_o, int_req;
   logic [1:0]        sync_q;
   logic [NSRC-1:0]   int_q;
   logic [2:0]        nicond_q, nicond_d;
   logic [NSTATE-1:0] ustate_q, ustate_d;
   logic [15:0]       status;

   assign clr_run = bus.diag_ctl && bus.diag_func == DF_CLR_RUN;
   assign set_run = bus.diag_ctl && bus.diag_func == DF_SET_RUN;
   assign cont    = bus.diag_ctl && bus.diag_func == DF_CONTINUE;
   assign bus.DIAG_IR_STROBE   = bus.diag_ctl && bus.diag_func == DF_IR_STROBE;
   assign bus.DIAG_DRAM_STROBE = bus.diag_ctl && bus.diag_func == DF_DRAM_STROBE;

   assign run_d   = clr_run ? 1'b0 : set_run ? 1'b1 : run_q;
   // The start request retires once START has been seen, so START is a single pulse.
   assign start_d = cont | (start_q & ~start_o);
   assign go_d    = cont | (go_q & bus.go_hold);
   assign int_req = |int_q & ~bus.int_disable;

   always_comb
      nicond_d = bus.pi_cycle         ? NC_PI     :
                 !run_o               ? NC_HALT   :
                 int_q[0]             ? NC_METER  :
                 int_req              ? NC_INT    :
                 ustate_q[NSTATE-1]   ? NC_USTATE :
                 !bus.ac_ref          ? NC_NOAC   : NC_NONE;

   // JK behaviour per flag: set forces 1, clr forces 0, both toggle.
   always_comb begin
      ustate_d = ustate_q;
      if (bus.ustate_en)
         for (int i = 0; i < NSTATE; i++)
            ustate_d[i] = (bus.ustate_mag[2*i+1] & ~ustate_q[i]) | (~bus.ustate_mag[2*i] & ustate_q[i]);
   end

   always_ff @(posedge clk or posedge RESET)
      if (RESET) begin
         run_q    <= 1'b0;
         start_q  <= 1'b0;
         go_q     <= 1'b0;
         int_q    <= '0;
         nicond_q <= NC_HALT;
         trap_q   <= 1'b0;
         ustate_q <= '0;
      end else begin
         run_q    <= run_d;
         start_q  <= start_d;
         go_q     <= go_d;
         int_q    <= bus.int_src;
         nicond_q <= nicond_d;
         trap_q   <= nicond_d[0];
         ustate_q <= ustate_d;
      end

   // Firing START flushes the start line so a held latch cannot stretch the pulse.
   sync_chain #(.STAGES(SYNC_STAGES), .W(2)) u_sync (
      .clk   (clk),
      .RESET (RESET),
      .d_i   ({start_q, run_q}),
      .clr_i ({start_o, 1'b0}),
      .q_o   (sync_q)
   );
   assign run_o   = sync_q[0];
   assign start_o = sync_q[1];

   always_comb begin
      status                       = '0;
      status[DD_RUN]               = run_o;
      status[DD_START]             = start_o;
      status[DD_GO]                = go_q;
      status[DD_INT]               = int_req;
      status[DD_TRAP]              = trap_q;
      status[DD_NICOND +: 3]       = nicond_q;
      status[DD_USTATE +: NSTATE]  = ustate_q;
   end

`ifdef CON_RUNCTL_HALTCNT_EN
   logic [15:0] hcnt_q;

   always_ff @(posedge clk or posedge RESET)
      if (RESET) hcnt_q <= '0;
      else if (set_run) hcnt_q <= '0;
      else if (!run_o && hcnt_q != 16'hFFFF) hcnt_q <= hcnt_q + 16'd1;

   assign bus.diag_data = !bus.diag_rd ? '0 : bus.diag_func == DF_HALTCNT ? hcnt_q : status;
`else
   assign bus.diag_data = bus.diag_rd ? status : '0;
`endif

   assign bus.RUN            = run_o;
   assign bus.START          = start_o;
   assign bus.INSTR_GO       = go_q;
   assign bus.INT_REQ        = int_req;
   assign bus.NICOND         = nicond_q;
   assign bus.NICOND_TRAP_EN = trap_q;
   assign bus.UCODE_STATE    = ustate_q;

endmodule

// File: doc/con_runctl.md
CON_RUNCTL -- requirements
Module: con_runctl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 3, RUN/START synchroniser depth (legal 1..8).
REQ-002 SHALL have parameter NSRC, default 4, number of interrupt request sources (legal 1..8).
REQ-003 SHALL have parameter NSTATE, default 4, number of microcode state flags (legal 1..8).
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with the following ports:
- clk  in  1  EBOX clock; all state updates on rising edge.
- RESET  in  1  asynchronous active-high master reset.
- diag_ctl  in  1  diagnostic control function strobe.
- diag_func  in  3  function code: 000 CLR_RUN, 001 SET_RUN, 010 CONTINUE, 100 IR_STROBE, 101 DRAM_STROBE; others no-op.
- int_src  in  NSRC  raw interrupt requests; bit 0 is the meter source.
- int_disable  in  1  masks all requests.
- go_hold  in  1  keeps INSTR_GO set (spec-flag-ctl & magic[3] & io_legal).
- pi_cycle  in  1  PI cycle active.
- ac_ref  in  1  VMA is an AC reference.
- ustate_en  in  1  microcode state-field load enable.
- ustate_mag  in  2*NSTATE  {set,clr} pair per state flag.
- diag_rd  in  1  diagnostic read select.
- RUN, START, INSTR_GO  out  1  run, start and instruction-go state.
- DIAG_IR_STROBE, DIAG_DRAM_STROBE  out  1  decoded one-cycle strobes.
- INT_REQ  out  1  any unmasked registered request.
- NICOND  out  3  registered next-instruction dispatch code.
- NICOND_TRAP_EN  out  1  registered, equals NICOND[0].
- UCODE_STATE  out  NSTATE  microcode state flags.
- diag_data  out  16  diagnostic status word; 0 when diag_rd=0.

Function
REQ-005 SHALL decode diag_func only while diag_ctl=1; decode is combinational; strobes deassert the cycle diag_ctl falls.
REQ-006 SHALL hold a run latch: set by SET_RUN, cleared by CLR_RUN or RESET; CLR_RUN wins over SET_RUN in the same cycle.
REQ-007 SHALL drive RUN from the run latch through exactly SYNC_STAGES registers, giving a latency of SYNC_STAGES cycles.
REQ-008 SHALL hold a start latch set by CONTINUE and cleared in the cycle after START is 1; START is the start latch delayed SYNC_STAGES cycles.
REQ-009 SHALL make INSTR_GO a register: set by CONTINUE, held while go_hold=1, cleared otherwise.
REQ-010 SHALL register int_src each cycle; INT_REQ = |(registered int_src) & ~int_disable.
REQ-011 SHALL compute NICOND priority, highest first: pi_cycle=1 -> 000; RUN=0 -> 001; registered int_src[0] -> 010; INT_REQ -> 011; UCODE_STATE[NSTATE-1] -> 100; ac_ref=0 -> 101; none -> 111.
REQ-012 SHALL register the REQ-011 code into NICOND one cycle after its inputs are sampled.
REQ-013 SHALL update each UCODE_STATE[i] while ustate_en=1: set=1 -> 1; clr=1 -> 0; both=1 -> toggle; neither -> hold. Flags hold while ustate_en=0.
REQ-014 SHALL form diag_data as {RUN, START, INSTR_GO, INT_REQ, NICOND_TRAP_EN, NICOND, UCODE_STATE zero-extended to 8}, LSB-aligned.
REQ-015 SHALL ignore diag_ctl glitches shorter than one clock, since all latches are synchronous.

Reset
REQ-016 SHALL, on RESET=1 and asynchronously, clear all latches, synchronisers, INSTR_GO, UCODE_STATE, and registered int_src, and set NICOND=001 and NICOND_TRAP_EN=0.
REQ-017 SHALL allow RESET asserted mid-synchronisation to abort pending RUN/START propagation; no pulse appears after release.

Configuration
REQ-018 SHALL, with CON_RUNCTL_HALTCNT_EN defined, add a 16-bit counter that increments each cycle RUN=0, saturates at FFFF, clears on the SET_RUN strobe or RESET, and replaces diag_data when diag_rd=1 and diag_func=111.
REQ-019 SHALL, without CON_RUNCTL_HALTCNT_EN, contain no counter, and diag_func=111 reads as REQ-014.

Structure
REQ-020 SHALL place the diag_func enum, NICOND code constants and the diag_data field offsets in a shared package, con_pkg.
REQ-021 SHALL implement the RUN and START delay lines as one sub-module, sync_chain, parametrised by SYNC_STAGES.

Verification
REQ-022 SHALL verify: RESET, then diag_ctl=1 with func=001 for one cycle -> RUN=1 exactly 3 cycles later and NICOND leaves 001.
REQ-023 SHALL verify: func=010 pulse -> START=1 for exactly one cycle after 3 cycles and INSTR_GO=1 next cycle, then cleared when go_hold=0.
REQ-024 SHALL verify: RUN=1, int_src=0001, int_disable=0 -> NICOND=010; pi_cycle=1 in the same cycle -> NICOND=000.
REQ-025 SHALL verify: func=000 and func=001 in one cycle -> RUN stays 0; int_disable=1 with int_src=1111 -> INT_REQ=0.
REQ-026 SHALL verify: ustate_en=1 with both set and clr for flag 2 -> UCODE_STATE[2] toggles each cycle; RESET mid-toggle -> 0.
REQ-027 SHALL verify: with HALTCNT_EN, 70000 cycles halted -> counter reads FFFF, then SET_RUN -> 0000.
